// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//   Oversampled UART receiver. Synchronises the serial line, detects the start
//   bit, recovers 5-8 data bits LSB first, checks optional even/odd parity and
//   one or two stop bits, and holds each frame plus its error flags in a
//   one-entry valid/ready register.
//
//   Build option: define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 2-of-3
//   vote over the samples at counter D-2, D-1 and D (default: the sample at D).
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   oversample_tick_i       one-clk pulse, OVERSAMPLING per bit period
//   rx_serial_i             asynchronous serial line, idle high
//   cfg_data_type_i         data bits 5..8 (other values mean 8)
//   cfg_parity_enable_i     parity bit present
//   cfg_parity_type_i       0 even, 1 odd
//   cfg_stop_bits_i         2 = two stop bits, else one
//   rx_data_o               received data, zero-extended
//   rx_parity_o             received parity bit (0 when disabled)
//   rx_*_error_o            status flags qualified by rx_valid_o
//   rx_valid_o/rx_ready_i   holding register handshake
//   rx_busy_o               receiver FSM is not idle
module uart_rx_deserializer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned OVERSAMPLING = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  oversample_tick_i,
    input  logic                  rx_serial_i,
    input  logic [3:0]            cfg_data_type_i,
    input  logic                  cfg_parity_enable_i,
    input  logic                  cfg_parity_type_i,
    input  logic [1:0]            cfg_stop_bits_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_parity_o,
    output logic                  rx_parity_error_o,
    output logic                  rx_framing_error_o,
    output logic                  rx_break_error_o,
    output logic                  rx_overrun_error_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  rx_busy_o
);

    localparam int unsigned CntW = $clog2(OVERSAMPLING);
    localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] StartDec = CntW'(OVERSAMPLING / 2 - 1);
    localparam logic [CntW-1:0] BitDec   = CntW'(OVERSAMPLING - 1);
    localparam logic [3:0]      MaxBits  = 4'(DATA_WIDTH);
    localparam logic [IdxW-1:0] MaxIdx   = IdxW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                state_q;
    logic                  sync1_q, sync2_q;
    logic                  rx_s;
    logic [CntW-1:0]       cnt_q;
    logic [IdxW-1:0]       bit_idx_q;
    logic [IdxW-1:0]       last_idx_q;
    logic                  stop_idx_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  armed_q;
    logic                  par_en_q, par_type_q, two_stop_q;
    logic                  par_bit_q, par_err_q, ferr_acc_q;

    logic [DATA_WIDTH-1:0] hold_data_q;
    logic                  hold_par_q, hold_perr_q, hold_ferr_q, hold_brk_q, hold_ovr_q;
    logic                  valid_q;

    logic                  sample_bit;
    logic                  tick_dec;
    logic                  exp_parity;
    logic                  last_stop;
    logic                  stop_ferr;
    logic                  frame_done;
    logic                  frame_break;
    logic [IdxW-1:0]       last_idx_d;

    // Two-flop synchroniser, idles high.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_serial_i;
            sync2_q <= sync1_q;
        end
    end
    assign rx_s = sync2_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Synced samples from the two ticks preceding the current one.
    logic [1:0] hist_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hist_q <= 2'b11;
        end else if (oversample_tick_i) begin
            hist_q <= {hist_q[0], rx_s};
        end
    end
    assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign sample_bit = rx_s;
`endif

    always_comb begin
        tick_dec    = oversample_tick_i && (cnt_q == BitDec);
        // Bits above the configured width stay zero, so a full-width XOR suffices.
        exp_parity  = par_type_q ? ~^shift_q : ^shift_q;
        last_stop   = !two_stop_q || stop_idx_q;
        stop_ferr   = ferr_acc_q | ~sample_bit;
        frame_done  = tick_dec && (state_q == StStop) && last_stop;
        frame_break = (shift_q == '0) && !par_bit_q && stop_ferr;
        if (cfg_data_type_i >= 4'd5 && cfg_data_type_i <= MaxBits) begin
            last_idx_d = IdxW'(cfg_data_type_i - 4'd1);
        end else begin
            last_idx_d = MaxIdx;
        end
    end

    // Receive FSM; all timing advances only on oversample ticks.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            last_idx_q <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            armed_q    <= 1'b1;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            two_stop_q <= 1'b0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            ferr_acc_q <= 1'b0;
        end else if (oversample_tick_i) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_s) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        state_q    <= StStart;
                        cnt_q      <= '0;
                        bit_idx_q  <= '0;
                        stop_idx_q <= 1'b0;
                        shift_q    <= '0;
                        par_bit_q  <= 1'b0;
                        par_err_q  <= 1'b0;
                        ferr_acc_q <= 1'b0;
                        last_idx_q <= last_idx_d;
                        par_en_q   <= cfg_parity_enable_i;
                        par_type_q <= cfg_parity_type_i;
                        two_stop_q <= (cfg_stop_bits_i == 2'd2);
                    end
                end
                StStart: begin
                    if (cnt_q == StartDec) begin
                        cnt_q   <= '0;
                        // A high decision means the falling edge was a glitch.
                        state_q <= sample_bit ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == BitDec) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= sample_bit;
                        if (bit_idx_q == last_idx_q) begin
                            state_q <= par_en_q ? StParity : StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    if (cnt_q == BitDec) begin
                        cnt_q     <= '0;
                        par_bit_q <= sample_bit;
                        par_err_q <= sample_bit ^ exp_parity;
                        state_q   <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == BitDec) begin
                        cnt_q      <= '0;
                        ferr_acc_q <= stop_ferr;
                        if (last_stop) begin
                            state_q <= StIdle;
                            // A held-low line must return high before the next start.
                            if (stop_ferr) begin
                                armed_q <= 1'b0;
                            end
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // One-entry holding register. A consume in the completion cycle frees the slot.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hold_data_q <= '0;
            hold_par_q  <= 1'b0;
            hold_perr_q <= 1'b0;
            hold_ferr_q <= 1'b0;
            hold_brk_q  <= 1'b0;
            hold_ovr_q  <= 1'b0;
            valid_q     <= 1'b0;
        end else if (frame_done && (!valid_q || rx_ready_i)) begin
            hold_data_q <= shift_q;
            hold_par_q  <= par_bit_q;
            hold_perr_q <= par_err_q;
            hold_ferr_q <= stop_ferr;
            hold_brk_q  <= frame_break;
            hold_ovr_q  <= 1'b0;
            valid_q     <= 1'b1;
        end else if (frame_done) begin
            // Slot still full: drop the new frame and flag the held word.
            hold_ovr_q <= 1'b1;
        end else if (valid_q && rx_ready_i) begin
            valid_q    <= 1'b0;
            hold_ovr_q <= 1'b0;
        end
    end

    assign rx_data_o          = hold_data_q;
    assign rx_parity_o        = hold_par_q;
    assign rx_parity_error_o  = hold_perr_q;
    assign rx_framing_error_o = hold_ferr_q;
    assign rx_break_error_o   = hold_brk_q;
    assign rx_overrun_error_o = hold_ovr_q;
    assign rx_valid_o         = valid_q;
    assign rx_busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: table of frames plus hand-written sequences
// for latency, glitch, break, overrun and mid-frame reset.
module tb_uart_rx_deserializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       rx;
    logic [3:0] cfg_bits;
    logic       cfg_pe;
    logic       cfg_pt;
    logic [1:0] cfg_stop;
    logic [7:0] rx_data;
    logic       rx_parity, rx_perr, rx_ferr, rx_brk, rx_ovr, rx_valid, rx_ready, rx_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       perr;
        logic       ferr;
        logic       brk;
        logic       ovr;
    } exp_t;

    typedef struct {
        logic [7:0] payload;
        logic [3:0] cfg_bits;
        int         tx_bits;
        logic       par_en;
        logic       par_type;
        logic       tx_par;
        logic [1:0] cfg_stop;
        int         tx_stops;
        logic       stop1;
        logic       stop2;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    uart_rx_deserializer #(
        .DATA_WIDTH  (8),
        .OVERSAMPLING(16)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .oversample_tick_i  (tick),
        .rx_serial_i        (rx),
        .cfg_data_type_i    (cfg_bits),
        .cfg_parity_enable_i(cfg_pe),
        .cfg_parity_type_i  (cfg_pt),
        .cfg_stop_bits_i    (cfg_stop),
        .rx_data_o          (rx_data),
        .rx_parity_o        (rx_parity),
        .rx_parity_error_o  (rx_perr),
        .rx_framing_error_o (rx_ferr),
        .rx_break_error_o   (rx_brk),
        .rx_overrun_error_o (rx_ovr),
        .rx_valid_o         (rx_valid),
        .rx_ready_i         (rx_ready),
        .rx_busy_o          (rx_busy)
    );

    // One tick every fourth clock.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h required %02h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic v);
        @(negedge clk);
        rx = v;
        wait_ticks(16);
    endtask

    // Aligns to a tick, sends one frame, then idles high for two bit times.
    task automatic send_frame(input logic [7:0] d, input int nbits, input logic pe,
                              input logic pb, input int nstop, input logic s1,
                              input logic s2);
        wait_ticks(1);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (pe) send_bit(pb);
        send_bit(s1);
        if (nstop == 2) send_bit(s2);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(32);
    endtask

    task automatic set_cfg(input logic [3:0] b, input logic pe, input logic pt,
                           input logic [1:0] s);
        cfg_bits = b;
        cfg_pe   = pe;
        cfg_pt   = pt;
        cfg_stop = s;
    endtask

    // Waits for a held word, compares it with the scoreboard head, then consumes it.
    task automatic consume(input string name);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        while (!rx_valid && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        chk1({name, " valid"}, rx_valid, 1'b1);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue required one entry", name);
            return;
        end
        e = sb.pop_front();
        chk8({name, " data"}, rx_data, e.data);
        chk1({name, " parity"}, rx_parity, e.par);
        chk1({name, " parity_err"}, rx_perr, e.perr);
        chk1({name, " framing_err"}, rx_ferr, e.ferr);
        chk1({name, " break_err"}, rx_brk, e.brk);
        chk1({name, " overrun_err"}, rx_ovr, e.ovr);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk1({name, " valid_drop"}, rx_valid, 1'b0);
    endtask

    task automatic chk_all_zero(input string name);
        chk8({name, " data"}, rx_data, 8'h00);
        chk1({name, " parity"}, rx_parity, 1'b0);
        chk1({name, " parity_err"}, rx_perr, 1'b0);
        chk1({name, " framing_err"}, rx_ferr, 1'b0);
        chk1({name, " break_err"}, rx_brk, 1'b0);
        chk1({name, " overrun_err"}, rx_ovr, 1'b0);
        chk1({name, " valid"}, rx_valid, 1'b0);
        chk1({name, " busy"}, rx_busy, 1'b0);
    endtask

    initial begin
        // payload cfg_bits tx_bits pe pt tx_par cfg_stop tx_stops stop1 stop2 expected
        vecs[0]  = '{8'hA5, 4'd8, 8, 1'b0, 1'b0, 1'b0, 2'd1, 1, 1'b1, 1'b1,
                     '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[1]  = '{8'h35, 4'd7, 7, 1'b1, 1'b0, 1'b1, 2'd1, 1, 1'b1, 1'b1,
                     '{8'h35, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[2]  = '{8'h35, 4'd7, 7, 1'b1, 1'b0, 1'b0, 2'd1, 1, 1'b1, 1'b1,
                     '{8'h35, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[3]  = '{8'h5A, 4'd8, 8, 1'b1, 1'b1, 1'b1, 2'd2, 2, 1'b1, 1'b1,
                     '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[4]  = '{8'hFF, 4'd5, 5, 1'b0, 1'b0, 1'b0, 2'd1, 1, 1'b1, 1'b1,
                     '{8'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[5]  = '{8'h3C, 4'd6, 6, 1'b1, 1'b1, 1'b0, 2'd1, 1, 1'b1, 1'b1,
                     '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[6]  = '{8'h81, 4'd0, 8, 1'b0, 1'b0, 1'b0, 2'd1, 1, 1'b1, 1'b1,
                     '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[7]  = '{8'h42, 4'd8, 8, 1'b0, 1'b0, 1'b0, 2'd1, 1, 1'b0, 1'b1,
                     '{8'h42, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[8]  = '{8'h99, 4'd8, 8, 1'b0, 1'b0, 1'b0, 2'd2, 2, 1'b1, 1'b0,
                     '{8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[9]  = '{8'h77, 4'd8, 8, 1'b0, 1'b0, 1'b0, 2'd0, 1, 1'b1, 1'b1,
                     '{8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[10] = '{8'h00, 4'd8, 8, 1'b1, 1'b0, 1'b1, 2'd1, 1, 1'b0, 1'b1,
                     '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[11] = '{8'h00, 4'd8, 8, 1'b0, 1'b0, 1'b0, 2'd1, 1, 1'b0, 1'b1,
                     '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}};
        vecs[12] = '{8'h00, 4'd5, 5, 1'b1, 1'b0, 1'b0, 2'd1, 1, 1'b0, 1'b1,
                     '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}};

        reset    = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        set_cfg(4'd8, 1'b0, 1'b0, 2'd1);
        repeat (5) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        wait_ticks(4);

        // 8N1 0xA5: exact valid latency, then valid held until a ready pulse.
        fork
            send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
            begin
                wait_ticks(1);
                @(negedge clk);
                wait_ticks(152);
                #1;
                chk1("latency busy_before", rx_busy, 1'b1);
                chk1("latency valid_before", rx_valid, 1'b0);
                wait_ticks(1);
                #1;
                chk1("latency valid_after", rx_valid, 1'b1);
                chk1("latency busy_after", rx_busy, 1'b0);
            end
        join
        repeat (50) @(negedge clk);
        chk1("a5 valid_held", rx_valid, 1'b1);
        sb.push_back('{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        consume("a5");

        for (int i = 0; i < 13; i++) begin
            set_cfg(vecs[i].cfg_bits, vecs[i].par_en, vecs[i].par_type, vecs[i].cfg_stop);
            send_frame(vecs[i].payload, vecs[i].tx_bits, vecs[i].par_en, vecs[i].tx_par,
                       vecs[i].tx_stops, vecs[i].stop1, vecs[i].stop2);
            sb.push_back(vecs[i].e);
            consume($sformatf("vec%0d", i));
        end

        // Glitch: low for 4 ticks; busy falls at the start-bit decision tick.
        set_cfg(4'd8, 1'b0, 1'b0, 2'd1);
        wait_ticks(1);
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(4);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(4);
        #1;
        chk1("glitch busy_before", rx_busy, 1'b1);
        wait_ticks(1);
        #1;
        chk1("glitch busy_after", rx_busy, 1'b0);
        wait_ticks(200);
        #1;
        chk1("glitch no_valid", rx_valid, 1'b0);

        // Line held low for 20 bit times: exactly one break word.
        wait_ticks(1);
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(200);
        sb.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        consume("break");
        wait_ticks(120);
        #1;
        chk1("break no_second_valid", rx_valid, 1'b0);
        chk1("break idle", rx_busy, 1'b0);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(32);
        #1;
        chk1("break line_high_no_valid", rx_valid, 1'b0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        sb.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        consume("after_break");

        // Overrun: 0x11 then 0x22 with ready low.
        send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        sb.push_back('{8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        consume("overrun");
        wait_ticks(64);
        #1;
        chk1("overrun no_second_word", rx_valid, 1'b0);

        // Reset during data bit 3 with a word held, then a fresh 8O2 0x5A.
        send_frame(8'h66, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        set_cfg(4'd8, 1'b1, 1'b1, 2'd2);
        wait_ticks(1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(8);
        @(negedge clk);
        chk1("pre_reset busy", rx_busy, 1'b1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("mid_reset");
        reset = 1'b0;
        wait_ticks(40);
        #1;
        chk1("post_reset no_valid", rx_valid, 1'b0);
        chk1("post_reset idle", rx_busy, 1'b0);
        send_frame(8'h5A, 8, 1'b1, 1'b1, 2, 1'b1, 1'b1);
        sb.push_back('{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        consume("post_reset_5a");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
